// File: rtl/alu_mul_seq.sv
// Sequential 8x8 -> 16-bit unsigned multiplier that borrows the shared ALU
// for every shift-add step (ADD, CMP_LS for the carry, LSR for both halves).
module alu_mul_seq #(
    parameter int unsigned           W        = 8,
    parameter int unsigned           Ops      = 5,
    parameter logic [Ops-1:0]        OP_ADD   = Ops'(16),
    parameter logic [Ops-1:0]        OP_CMPLS = Ops'(13),
    parameter logic [Ops-1:0]        OP_LSR   = Ops'(15)
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic [W-1:0]   MulA,
    input  logic [W-1:0]   MulB,
    output logic           Busy,
    output logic           Done,
    output logic [W-1:0]   ProdHi,
    output logic [W-1:0]   ProdLo,
    output logic           AluReq,
    input  logic           AluGnt,
    output logic [Ops-1:0] AluOp,
    output logic [W-1:0]   AluA,
    output logic [W-1:0]   AluB,
    input  logic [W-1:0]   AluOut
);

    typedef enum logic [2:0] {
        IDLE,
        S_ADD,
        S_CMP,
        S_SHL,
        S_SHH
    } state_t;

    state_t       state, state_n;
    logic [W-1:0] a_q;
    logic [W-1:0] t_q;
    logic         c_q;
    logic         bit_q;
    logic [2:0]   cnt_q;
    logic [W-1:0] prod_hi_q;
    logic [W-1:0] prod_lo_q;
    logic         done_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ALU operands are combinational from state: the ALU answers in the same cycle.
    always_comb begin
        state_n = state;
        AluOp   = '0;
        AluA    = '0;
        AluB    = '0;
        case (state)
            IDLE: begin
                if (Start) state_n = S_ADD;
            end
            S_ADD: begin
                AluOp = OP_ADD;
                AluA  = prod_hi_q;
                AluB  = a_q;
                if (AluGnt) state_n = S_CMP;
            end
            S_CMP: begin
                AluOp = OP_CMPLS;
                AluA  = t_q;
                AluB  = a_q;
                if (AluGnt) state_n = S_SHL;
            end
            S_SHL: begin
                AluOp = OP_LSR;
                AluA  = prod_lo_q;
                if (AluGnt) state_n = S_SHH;
            end
            S_SHH: begin
                AluOp = OP_LSR;
                AluA  = t_q;
                if (AluGnt) state_n = (cnt_q == 3'd7) ? IDLE : S_ADD;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_q       <= '0;
            t_q       <= '0;
            c_q       <= 1'b0;
            bit_q     <= 1'b0;
            cnt_q     <= '0;
            prod_hi_q <= '0;
            prod_lo_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        a_q       <= MulA;
                        prod_hi_q <= '0;
                        prod_lo_q <= MulB;
                        cnt_q     <= '0;
                    end
                end
                S_ADD: begin
                    if (AluGnt) begin
                        t_q   <= AluOut;
                        bit_q <= prod_lo_q[0];
                    end
                end
                S_CMP: begin
                    // A wrapped sum smaller than the addend means the add carried out.
                    if (AluGnt) begin
                        c_q <= bit_q & AluOut[0];
                        if (!bit_q) t_q <= prod_hi_q;
                    end
                end
                S_SHL: begin
                    if (AluGnt) prod_lo_q <= {t_q[0], AluOut[W-2:0]};
                end
                S_SHH: begin
                    if (AluGnt) begin
                        prod_hi_q <= {c_q, AluOut[W-2:0]};
                        cnt_q     <= cnt_q + 3'd1;
                        if (cnt_q == 3'd7) done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Busy   = (state != IDLE);
    assign AluReq = Busy;
    assign Done   = done_q;
    assign ProdHi = prod_hi_q;
    assign ProdLo = prod_lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural ALU beside the DUT, products and
// latencies predicted from plain arithmetic, immediate assertions per check.
module tb_alu_mul_seq;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic [7:0] MulA, MulB;
    logic       Busy, Done;
    logic [7:0] ProdHi, ProdLo;
    logic       AluReq, AluGnt;
    logic [4:0] AluOp;
    logic [7:0] AluA, AluB, AluOut;

    int nerr = 0;
    int nchk = 0;

    alu_mul_seq #(.W(8), .Ops(5)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .MulA(MulA), .MulB(MulB),
        .Busy(Busy), .Done(Done), .ProdHi(ProdHi), .ProdLo(ProdLo),
        .AluReq(AluReq), .AluGnt(AluGnt), .AluOp(AluOp), .AluA(AluA),
        .AluB(AluB), .AluOut(AluOut)
    );

    always #5 Clk = ~Clk;

    // Shared ALU as the core would present it.
    always_comb begin
        AluOut = 8'h00;
        case (AluOp)
            5'd16: AluOut = AluA + AluB;
            5'd13: AluOut = {7'b0, (AluA < AluB)};
            5'd15: AluOut = AluA >> 1;
            default: AluOut = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Runs until Done; gnt mode 0=always, 1=deny every other busy cycle, 2=random.
    task automatic wait_done(input int mode, input bit hold, input logic [7:0] na,
                             input logic [7:0] nb, output int cycles,
                             output int denied, output int steps);
        logic       prev_den;
        logic [4:0] pop;
        logic [7:0] pa, pb;
        cycles = 0; denied = 0; steps = 0; prev_den = 1'b0;
        pop = '0; pa = '0; pb = '0;
        forever begin
            tick();
            cycles++;
            if (!hold) Start = 1'b0;
            else if (cycles == 1) begin MulA = na; MulB = nb; end
            if (Done) break;
            if (cycles > 300) begin
                check("done_timeout", 32'(cycles), 32'd0);
                break;
            end
            if (prev_den) begin
                check("held_op", 32'(AluOp), 32'(pop));
                check("held_a", 32'(AluA), 32'(pa));
                check("held_b", 32'(AluB), 32'(pb));
            end
            case (mode)
                1: AluGnt = cycles[0];
                2: AluGnt = ($urandom % 4) != 0;
                default: AluGnt = 1'b1;
            endcase
            prev_den = Busy && !AluGnt;
            if (prev_den) begin
                denied++; pop = AluOp; pa = AluA; pb = AluB;
            end
            if (Busy && AluGnt) steps++;
        end
        AluGnt = 1'b1;
    endtask

    task automatic mul_run(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input int mode);
        int cyc, den, stp;
        Start = 1'b1; MulA = a; MulB = b;
        wait_done(mode, 1'b0, 8'h00, 8'h00, cyc, den, stp);
        check({tag, "_prod"}, 32'({ProdHi, ProdLo}), 32'(a) * 32'(b));
        check({tag, "_lat"}, 32'(cyc), 32'(33 + den));
        check({tag, "_steps"}, 32'(stp), 32'd32);
        check({tag, "_busy_at_done"}, 32'(Busy), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(Done), 32'd0);
        check({tag, "_hold_prod"}, 32'({ProdHi, ProdLo}), 32'(a) * 32'(b));
    endtask

    initial begin
        int cyc, den, stp, ndone;
        logic [7:0] ra, rb;
        Reset = 1'b1; Start = 1'b0; MulA = '0; MulB = '0; AluGnt = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_req", 32'(AluReq), 32'd0);
        check("rst_prod", 32'({ProdHi, ProdLo}), 32'd0);
        check("rst_alu", 32'({AluOp, AluA, AluB}), 32'd0);

        mul_run("d0b", 8'h0D, 8'h0B, 0);
        check("d0b_exact", 32'({ProdHi, ProdLo}), 32'h008F);
        mul_run("ffff", 8'hFF, 8'hFF, 0);
        check("ffff_exact", 32'({ProdHi, ProdLo}), 32'hFE01);
        mul_run("x80", 8'h80, 8'h02, 0);
        mul_run("zeroA", 8'h00, 8'hA5, 0);
        mul_run("zeroB", 8'hA5, 8'h00, 0);
        check("idle_alu", 32'({AluOp, AluA, AluB}), 32'd0);

        Start = 1'b1; MulA = 8'h0D; MulB = 8'h0B;
        wait_done(1, 1'b0, 8'h00, 8'h00, cyc, den, stp);
        check("deny_prod", 32'({ProdHi, ProdLo}), 32'h008F);
        check("deny_lat", 32'(cyc), 32'(33 + den));
        check("deny_some", 32'(den > 0), 32'd1);
        tick();

        // Reset in the middle of a run: abort without Done.
        Start = 1'b1; MulA = 8'h37; MulB = 8'h59;
        tick(); Start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("pre_rst_busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("mid_rst_busy", 32'(Busy), 32'd0);
        check("mid_rst_out", 32'({Done, AluReq, ProdHi, ProdLo}), 32'd0);
        check("mid_rst_alu", 32'({AluOp, AluA, AluB}), 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Done) ndone++;
        end
        check("mid_rst_nodone", 32'(ndone), 32'd0);
        mul_run("after_rst", 8'h37, 8'h59, 0);

        // Start held: new operands ignored while busy, accepted on Done.
        Start = 1'b1; MulA = 8'h9C; MulB = 8'h2B;
        wait_done(0, 1'b1, 8'h47, 8'hE3, cyc, den, stp);
        check("b2b_prod1", 32'({ProdHi, ProdLo}), 32'h9C * 32'h2B);
        check("b2b_lat1", 32'(cyc), 32'd33);
        wait_done(0, 1'b0, 8'h00, 8'h00, cyc, den, stp);
        check("b2b_prod2", 32'({ProdHi, ProdLo}), 32'h47 * 32'hE3);
        check("b2b_lat2", 32'(cyc), 32'd33);
        tick();

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            mul_run("rand", ra, rb, 2);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
